// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer: turns one (dev, reg, rw, len) command into a series
// of byte slots for a downstream I2C byte master, paced by the master's busy edges.
module i2c_reg_sequencer #(
  parameter int TIMEOUT  = 200000,
  parameter int STOP_GAP = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_we,
  input  logic [2:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic       cmd_rw,
  input  logic [2:0] cmd_len,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic [1:0] err,
  output logic       m_enable,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic       m_busy,
  input  logic       m_ack_error,
  input  logic [7:0] m_data_rd
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(STOP_GAP + 1);

  typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic            rw_q, rw_d;
  logic [2:0]      len_q, len_d;
  logic [7:0][7:0] buf_q, buf_d;
  logic [3:0]      slot_q, slot_d;
  logic [3:0]      fly_q, fly_d;
  logic            busy_q;
  logic            m_enable_q, m_enable_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic            m_rw_q, m_rw_d;
  logic [7:0]      m_data_wr_q, m_data_wr_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            done_q, done_d;
  logic [1:0]      err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic       rise, fall;
  logic [3:0] last_slot;

  assign rise      = m_busy & ~busy_q;
  assign fall      = ~m_busy & busy_q;
  assign last_slot = {1'b0, len_q} + 4'd1;

  assign cmd_ready = (state_q == IDLE);
  assign m_enable  = m_enable_q;
  assign m_addr    = m_addr_q;
  assign m_rw      = m_rw_q;
  assign m_data_wr = m_data_wr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    rw_d        = rw_q;
    len_d       = len_q;
    buf_d       = buf_q;
    slot_d      = slot_q;
    fly_d       = fly_q;
    m_enable_d  = m_enable_q;
    m_addr_d    = m_addr_q;
    m_rw_d      = m_rw_q;
    m_data_wr_d = m_data_wr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    case (state_q)
      IDLE: begin
        if (wr_we) buf_d[wr_idx] = wr_data;
        if (cmd_valid) begin
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          rw_d    = cmd_rw;
          len_d   = cmd_len;
          err_d   = 2'b00;
          tmo_d   = '0;
          state_d = START;
        end
      end
      START: begin
        m_enable_d  = 1'b1;
        m_addr_d    = dev_q;
        m_rw_d      = 1'b0;
        m_data_wr_d = reg_q;
        slot_d      = 4'd0;
        fly_d       = 4'd0;
        tmo_d       = '0;
        state_d     = XFER;
      end
      XFER: begin
        if (rise) begin
          // Master has latched slot_q; present the following slot while it shifts.
          tmo_d = '0;
          fly_d = slot_q;
          if (slot_q == last_slot) begin
            m_enable_d = 1'b0;
            gap_d      = '0;
            state_d    = DRAIN;
          end else begin
            slot_d      = slot_q + 4'd1;
            m_rw_d      = rw_q;
            m_data_wr_d = rw_q ? 8'h00 : buf_q[slot_q[2:0]];
          end
        end else if (fall) begin
          tmo_d = '0;
          if (m_ack_error) begin
            m_enable_d = 1'b0;
            err_d      = 2'b01;
            gap_d      = '0;
            state_d    = DRAIN;
          end else if (rw_q && fly_q != 4'd0) begin
            rd_data_d  = m_data_rd;
            rd_valid_d = 1'b1;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          m_enable_d = 1'b0;
          err_d      = 2'b10;
          gap_d      = '0;
          state_d    = DRAIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DRAIN: begin
        // The last slot still completes here; a failed command ignores further edges.
        if (fall && err_q == 2'b00) begin
          if (m_ack_error) begin
            err_d = 2'b01;
          end else if (rw_q && fly_q != 4'd0) begin
            rd_data_d  = m_data_rd;
            rd_valid_d = 1'b1;
          end
        end
        if (m_busy) begin
          gap_d = '0;
        end else if (gap_q == GW'(STOP_GAP - 1)) begin
          gap_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dev_q       <= '0;
      reg_q       <= '0;
      rw_q        <= 1'b0;
      len_q       <= '0;
      slot_q      <= '0;
      fly_q       <= '0;
      busy_q      <= 1'b0;
      m_enable_q  <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_wr_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 2'b00;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      rw_q        <= rw_d;
      len_q       <= len_d;
      slot_q      <= slot_d;
      fly_q       <= fly_d;
      busy_q      <= m_busy;
      m_enable_q  <= m_enable_d;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_data_wr_q <= m_data_wr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
    end
  end

  // Write buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural I2C byte-master/slave model.
module tb_i2c_reg_sequencer;
  localparam int TIMEOUT  = 50;
  localparam int STOP_GAP = 20;
  localparam int BYTE_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_we = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [7:0] wr_data = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0;
  logic       cmd_rw = 1'b0;
  logic [2:0] cmd_len = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic [1:0] err;
  logic       m_enable;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_wr;
  logic       m_busy;
  logic       m_ack_error;
  logic [7:0] m_data_rd;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.TIMEOUT(TIMEOUT), .STOP_GAP(STOP_GAP)) dut (
    .clk(clk), .rst(rst), .wr_we(wr_we), .wr_idx(wr_idx), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg),
    .cmd_rw(cmd_rw), .cmd_len(cmd_len), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw),
    .m_data_wr(m_data_wr), .m_busy(m_busy), .m_ack_error(m_ack_error), .m_data_rd(m_data_rd)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ent(input logic [6:0] a, input logic r, input logic [7:0] d);
    return {a, r, d};
  endfunction

  // byte-master model state
  logic        model_en = 1'b1;
  logic [6:0]  nack_dev = 7'h7F;
  logic [7:0]  rd_src[$];
  logic [15:0] log_q[$];
  logic        ena_end_q[$];
  logic [7:0]  rd_got[$];
  int          done_cnt = 0;

  initial begin : model
    logic [6:0] a;
    logic       r;
    logic [7:0] d;
    logic       abort;
    m_busy = 1'b0; m_ack_error = 1'b0; m_data_rd = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst && model_en && m_enable) begin
        a = m_addr; r = m_rw; d = m_data_wr;
        m_busy = 1'b1; m_ack_error = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < BYTE_CYC; i++) begin
          @(posedge clk); #1;
          if (rst) begin abort = 1'b1; break; end
        end
        if (!abort) begin
          log_q.push_back({a, r, d});
          ena_end_q.push_back(m_enable);
          if (r && rd_src.size() > 0) m_data_rd = rd_src.pop_front();
          m_ack_error = (a == nack_dev);
        end
        m_busy = 1'b0;
        repeat (3) @(posedge clk);
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid) rd_got.push_back(rd_data);
    if (done) done_cnt++;
  end

  task automatic wr_buf(input logic [2:0] i, input logic [7:0] d);
    @(negedge clk); wr_we = 1'b1; wr_idx = i; wr_data = d;
    @(negedge clk); wr_we = 1'b0;
  endtask

  task automatic issue(input logic [6:0] dv, input logic [7:0] rg, input logic rw, input logic [2:0] ln);
    int w;
    w = 0;
    log_q.delete(); ena_end_q.delete(); rd_got.delete(); done_cnt = 0;
    @(negedge clk);
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    chk("ready", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_dev = dv; cmd_reg = rg; cmd_rw = rw; cmd_len = ln;
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output logic [1:0] e);
    cyc = 1;
    while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("done_seen", {31'd0, done}, 1);
    e = err;
    repeat (6) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin : main
    int         cyc;
    int         w;
    logic [1:0] e;

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", {3'd0, m_enable, m_addr, m_rw, m_data_wr, rd_data, rd_valid, done, err}, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);

    // register write, with ignored buffer write / command while busy
    wr_buf(3'd0, 8'hA5); wr_buf(3'd1, 8'h3C);
    issue(7'h50, 8'h10, 1'b0, 3'd1);
    @(negedge clk);
    wr_we = 1'b1; wr_idx = 3'd0; wr_data = 8'hFF;
    cmd_valid = 1'b1; cmd_dev = 7'h11; cmd_len = 3'd7;
    @(negedge clk); wr_we = 1'b0; cmd_valid = 1'b0;
    wait_done(cyc, e);
    chk("w_n", log_q.size(), 3);
    chk("w_b0", {16'd0, log_q[0]}, {16'd0, ent(7'h50, 1'b0, 8'h10)});
    chk("w_b1", {16'd0, log_q[1]}, {16'd0, ent(7'h50, 1'b0, 8'hA5)});
    chk("w_b2", {16'd0, log_q[2]}, {16'd0, ent(7'h50, 1'b0, 8'h3C)});
    chk("w_err", {30'd0, e}, 0);
    chk("w_done1", done_cnt, 1);
    chk("w_nord", rd_got.size(), 0);

    // buffer persists; busy-time write was dropped
    issue(7'h50, 8'h20, 1'b0, 3'd0);
    wait_done(cyc, e);
    chk("p_n", log_q.size(), 2);
    chk("p_b1", {16'd0, log_q[1]}, {16'd0, ent(7'h50, 1'b0, 8'hA5)});

    // single-byte register read
    rd_src.delete(); rd_src.push_back(8'h71);
    issue(7'h68, 8'h75, 1'b1, 3'd0);
    wait_done(cyc, e);
    chk("r1_n", log_q.size(), 2);
    chk("r1_b0", {16'd0, log_q[0]}, {16'd0, ent(7'h68, 1'b0, 8'h75)});
    chk("r1_b1", {16'd0, log_q[1]}, {16'd0, ent(7'h68, 1'b1, 8'h00)});
    chk("r1_cnt", rd_got.size(), 1);
    chk("r1_dat", {24'd0, rd_got[0]}, 32'h71);
    chk("r1_err", {30'd0, e}, 0);

    // 8-byte read
    rd_src.delete();
    for (int i = 1; i <= 8; i++) rd_src.push_back(8'(i * 8'h11));
    issue(7'h1A, 8'h00, 1'b1, 3'd7);
    wait_done(cyc, e);
    chk("r8_n", log_q.size(), 9);
    chk("r8_cnt", rd_got.size(), 8);
    for (int i = 0; i < 8; i++) chk("r8_dat", {24'd0, rd_got[i]}, (i + 1) * 32'h11);
    chk("r8_ena7", {31'd0, ena_end_q[7]}, 1);
    chk("r8_nack_last", {31'd0, ena_end_q[8]}, 0);
    chk("r8_err", {30'd0, e}, 0);

    // address NACK
    nack_dev = 7'h2C;
    issue(7'h2C, 8'h01, 1'b0, 3'd1);
    wait_done(cyc, e);
    nack_dev = 7'h7F;
    chk("nk_n", log_q.size(), 1);
    chk("nk_err", {30'd0, e}, 1);
    chk("nk_done1", done_cnt, 1);

    // timeout: master never goes busy
    model_en = 1'b0;
    issue(7'h33, 8'h00, 1'b0, 3'd0);
    wait_done(cyc, e);
    model_en = 1'b1;
    chk("to_err", {30'd0, e}, 2);
    chk("to_lat", {31'd0, (cyc >= TIMEOUT + STOP_GAP && cyc <= TIMEOUT + STOP_GAP + 3)}, 1);
    chk("to_n", log_q.size(), 0);

    // reset during slot 2 of a read
    rd_src.delete();
    rd_src.push_back(8'hC1); rd_src.push_back(8'hC2); rd_src.push_back(8'hC3); rd_src.push_back(8'hC4);
    issue(7'h44, 8'h02, 1'b1, 3'd3);
    w = 0;
    while (!(log_q.size() == 2 && m_busy) && w < 1000) begin @(negedge clk); w++; end
    chk("mr_reach", log_q.size(), 2);
    chk("mr_pre_rd", {24'd0, rd_data}, 32'hC1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_outs", {3'd0, m_enable, m_addr, m_rw, m_data_wr, rd_data, rd_valid, done, err}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("mr_ready", {31'd0, cmd_ready}, 1);
    rd_src.delete();
    wr_buf(3'd0, 8'h5A); wr_buf(3'd1, 8'hC3);
    issue(7'h50, 8'h10, 1'b0, 3'd1);
    wait_done(cyc, e);
    chk("mr_n", log_q.size(), 3);
    chk("mr_b1", {16'd0, log_q[1]}, {16'd0, ent(7'h50, 1'b0, 8'h5A)});
    chk("mr_b2", {16'd0, log_q[2]}, {16'd0, ent(7'h50, 1'b0, 8'hC3)});
    chk("mr_err", {30'd0, e}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200000, meaning the maximum clk cycles to wait for any m_busy edge before aborting.
REQ-002 SHALL have parameter STOP_GAP, default 1000, meaning the clk cycles to wait after the final m_busy fall before reporting done (STOP completes).
REQ-003 SHALL have port clk, input, 1, system clock (all logic on rising edge).
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port wr_we, input, 1, write strobe for the write-data buffer; honoured only in IDLE.
REQ-006 SHALL have port wr_idx, input, 3, write-buffer entry index.
REQ-007 SHALL have port wr_data, input, 8, write-buffer entry data.
REQ-008 SHALL have port cmd_valid, input, 1, command request.
REQ-009 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-010 SHALL have port cmd_dev, input, 7, 7-bit slave address.
REQ-011 SHALL have port cmd_reg, input, 8, slave register address.
REQ-012 SHALL have port cmd_rw, input, 1, 0=register write, 1=register read.
REQ-013 SHALL have port cmd_len, input, 3, data byte count minus one (1..8 bytes).
REQ-014 SHALL have port rd_data, output, 8, received byte.
REQ-015 SHALL have port rd_valid, output, 1, one-cycle strobe qualifying rd_data.
REQ-016 SHALL have port done, output, 1, one-cycle strobe at command end.
REQ-017 SHALL have port err, output, 2, status valid with done: 00 ok, 01 NACK, 10 timeout.
REQ-018 SHALL have ports m_enable (output, 1), m_addr (output, 7), m_rw (output, 1), m_data_wr (output, 8), m_busy (input, 1), m_ack_error (input, 1), m_data_rd (input, 8), connected to the downstream I2C byte master.

Function
REQ-019 SHALL accept a command when cmd_valid && cmd_ready, latching cmd_dev, cmd_reg, cmd_rw and cmd_len, then enter START.
REQ-020 SHALL sequence slots 0..N with N=cmd_len+1: slot 0 is (dev, rw=0, data=cmd_reg); write-command slots k≥1 are (dev, rw=0, data=buf[k-1]); read-command slots k≥1 are (dev, rw=1, data=don't care, 00).
REQ-021 SHALL, in START, drive slot-0 values with m_enable=1 and enter XFER.
REQ-022 SHALL detect m_busy edges from a registered copy of m_busy (one-cycle detection latency).
REQ-023 SHALL, on each m_busy rise in XFER for slot i, drive slot i+1 values the next cycle; when i=N, drive m_enable=0 and enter DRAIN.
REQ-024 SHALL, on each m_busy fall, capture m_data_rd into rd_data with a rd_valid pulse when the completed slot is a read slot (read command, slot≥1).
REQ-025 SHALL, on any m_busy fall where m_ack_error=1, drive m_enable=0 immediately, latch err=01, ignore later edges, and enter DRAIN.
REQ-026 SHALL, in DRAIN, wait for m_busy=0, then count STOP_GAP cycles, then pulse done for one cycle and return to IDLE.
REQ-027 SHALL restart a TIMEOUT counter at each m_busy edge and on entering START; on expiry in START/XFER it SHALL drive m_enable=0, latch err=10, and enter DRAIN.
REQ-028 SHALL hold m_addr, m_rw and m_data_wr stable except on the cycle after a counted m_busy rise.
REQ-029 SHALL ignore cmd_valid and wr_we outside IDLE; the buffer content SHALL persist between commands.
REQ-030 SHALL clear err to 00 on command acceptance.
REQ-031 SHALL have state encoding IDLE, START, XFER, DRAIN; no other reachable states.

Reset
REQ-032 SHALL, on rst asserted at any time including mid-transfer, force IDLE, m_enable=0, cmd_ready=1 after release, m_addr=0, m_rw=0, m_data_wr=0, rd_data=0, rd_valid=0, done=0, err=00, counters 0; buffer contents undefined.

Verification
REQ-033 SHALL be verified with: buf={A5,3C}, write cmd dev=0x50 reg=0x10 len=1 -> slave sees 50W 10 A5 3C, done with err=00.
REQ-034 SHALL be verified with: read cmd dev=0x68 reg=0x75 len=0, slave returns 0x71 -> 68W 75, repeated start 68R, rd_data=71 one pulse, done with err=00.
REQ-035 SHALL be verified with: 8-byte read -> exactly 8 rd_valid pulses in order, master NACKs the last byte.
REQ-036 SHALL be verified with: slave NACKs the address -> m_enable drops after the first m_busy fall, no further slots, err=01.
REQ-037 SHALL be verified with: m_busy held 0 with TIMEOUT=50 -> done 50+STOP_GAP cycles later with err=10.
REQ-038 SHALL be verified with: rst asserted during slot 2 -> all outputs return to reset values, next command runs normally.
